// File: rtl/ula_op_sequencer_if.sv
// rtl/ula_op_sequencer_if.sv - request/result handshake bundle for the ULA op sequencer
interface ula_op_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        sign_flag;
   logic        zero_flag;
   logic        err;

   // Requester side: issues operations and consumes results
   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, sign_flag, zero_flag, err
   );

   // Sequencer side
   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, sign_flag, zero_flag, err
   );
endinterface

// File: rtl/ula_op_sequencer.sv
// rtl/ula_op_sequencer.sv - ADD/SUB/Booth MUL sequencer over one shared 16-bit ripple-carry adder

// Plain 16-bit ripple-carry adder, carry-in tied low; the carry out of bit 15 is never formed
module ula_ripple_adder16 (
   input  logic [15:0] x,
   input  logic [15:0] y,
   output logic [15:0] sum
);
   logic [15:0] carry;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < 15; i++) begin : g_carry
      assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
   end

   assign sum = x ^ y ^ carry;
endmodule

module ula_op_sequencer #(
   parameter int MUL_STEPS = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   ula_op_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [3:0] LAST_STEP = 4'(MUL_STEPS - 1);

   state_t      state;
   logic        in_ready_r;
   logic        out_valid_r;
   logic [15:0] result_r;
   logic        sign_r;
   logic        zero_r;
   logic        err_r;

   logic [1:0]  op_r;
   logic [7:0]  a_r;
   logic [7:0]  b_r;
   logic [3:0]  step_cnt;

   // Booth working registers: accumulator, multiplier and the bit shifted out below it
   logic [8:0]  acc;
   logic [7:0]  q;
   logic        qm1;

   logic [15:0] sext_a;
   logic [15:0] sext_b;
   logic [15:0] neg_a;
   logic [15:0] neg_b;
   logic [15:0] add_x;
   logic [15:0] add_y;
   logic [15:0] add_sum;

   logic [8:0]  acc_sum;
   logic [8:0]  acc_sh;
   logic [7:0]  q_sh;
   logic        qm1_sh;
   logic [15:0] mul_res;

   assign sext_a = {{8{a_r[7]}}, a_r};
   assign sext_b = {{8{b_r[7]}}, b_r};
   assign neg_a  = ~sext_a + 16'd1;
   assign neg_b  = ~sext_b + 16'd1;

   // Steer the operands of the current step into the shared adder
   always_comb begin
      add_x = '0;
      add_y = '0;
      if (state == S_CALC) begin
         case (op_r)
            OP_ADD: begin
               add_x = sext_a;
               add_y = sext_b;
            end
            OP_SUB: begin
               add_x = sext_a;
               add_y = neg_b;
            end
            OP_MUL: begin
               add_x = {{7{acc[8]}}, acc};
               case ({q[0], qm1})
                  2'b01:   add_y = sext_a;
                  2'b10:   add_y = neg_a;
                  default: add_y = '0;
               endcase
            end
            default: begin
               add_x = '0;
               add_y = '0;
            end
         endcase
      end
   end

   ula_ripple_adder16 u_adder (
      .x   (add_x),
      .y   (add_y),
      .sum (add_sum)
   );

   // Booth step tail: keep the 9-bit accumulator, then arithmetic-shift {acc, q, qm1} right by one
   assign acc_sum = add_sum[8:0];
   assign acc_sh  = {acc_sum[8], acc_sum[8:1]};
   assign q_sh    = {acc_sum[0], q[7:1]};
   assign qm1_sh  = q[0];
   assign mul_res = {acc_sh[7:0], q_sh};

   // Sequencer FSM with registered handshake, result and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         result_r    <= '0;
         sign_r      <= 1'b0;
         zero_r      <= 1'b0;
         err_r       <= 1'b0;
         op_r        <= '0;
         a_r         <= '0;
         b_r         <= '0;
         step_cnt    <= '0;
         acc         <= '0;
         q           <= '0;
         qm1         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               in_ready_r <= 1'b1;
               if (bus.in_valid && in_ready_r) begin
                  op_r       <= bus.op;
                  a_r        <= bus.a;
                  b_r        <= bus.b;
                  acc        <= '0;
                  q          <= bus.b;
                  qm1        <= 1'b0;
                  step_cnt   <= '0;
                  in_ready_r <= 1'b0;
                  state      <= S_CALC;
               end
            end

            S_CALC: begin
               case (op_r)
                  OP_ADD, OP_SUB: begin
                     result_r    <= add_sum;
                     sign_r      <= add_sum[15];
                     zero_r      <= (add_sum == 16'h0000);
                     err_r       <= 1'b0;
                     out_valid_r <= 1'b1;
                     state       <= S_DONE;
                  end
                  OP_MUL: begin
                     acc      <= acc_sh;
                     q        <= q_sh;
                     qm1      <= qm1_sh;
                     step_cnt <= step_cnt + 4'd1;
                     if (step_cnt == LAST_STEP) begin
                        result_r    <= mul_res;
                        sign_r      <= mul_res[15];
                        zero_r      <= (mul_res == 16'h0000);
                        err_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                     end
                  end
                  default: begin
                     result_r    <= '0;
                     sign_r      <= 1'b0;
                     zero_r      <= 1'b1;
                     err_r       <= 1'b1;
                     out_valid_r <= 1'b1;
                     state       <= S_DONE;
                  end
               endcase
            end

            S_DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= S_IDLE;
               end
            end

            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.sign_flag = sign_r;
   assign bus.zero_flag = zero_r;
   assign bus.err       = err_r;
endmodule
